// File: rtl/enc_share_arbiter_if.sv
// Bundle between the shared-encoder arbiter, its requesters, the encoder
// datapath and the response consumer.
//
// Handshake semantics: an EN_* strobe is a request from the other side and is
// honoured only in a cycle where the matching RDY_* is 1 at the rising edge;
// an EN_* seen while RDY_* is 0 has no effect. RDY_* never depends
// combinationally on EN_*. enc_valid marks the single cycle in which enc_src
// is meaningful and enc_result must be settled.
interface enc_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int VW   = 32,
    parameter int IW   = 6
);
    logic [NREQ-1:0]         EN_req;
    logic [NREQ*VW-1:0]      req_vec;
    logic [NREQ-1:0]         RDY_req;
    logic [VW-1:0]           enc_src;
    logic                    enc_valid;
    logic [IW-1:0]           enc_result;
    logic                    RDY_resp;
    logic [$clog2(NREQ)-1:0] resp_id;
    logic [IW-1:0]           resp_idx;
    logic                    resp_zero;
    logic                    EN_resp;
    logic                    mv_busy;
    logic                    RDY_mv_busy;

    // Arbiter side.
    modport slave (
        input  EN_req, req_vec, enc_result, EN_resp,
        output RDY_req, enc_src, enc_valid, RDY_resp, resp_id, resp_idx,
               resp_zero, mv_busy, RDY_mv_busy
    );

    // Requesters, encoder and consumer side.
    modport master (
        output EN_req, req_vec, enc_result, EN_resp,
        input  RDY_req, enc_src, enc_valid, RDY_resp, resp_id, resp_idx,
               resp_zero, mv_busy, RDY_mv_busy
    );
endinterface

// File: rtl/enc_share_arbiter.sv
// Shares one external leading-one encoder among NREQ requesters. Each
// requester owns a one-entry holding slot; a round-robin pointer picks the
// next slot, drives it to the encoder for one cycle, captures the index and
// holds it on the response port until the consumer takes it.
module enc_share_arbiter #(
    parameter int NREQ = 4,
    parameter int VW   = 32,
    parameter int IW   = 6
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    enc_share_arbiter_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [NREQ-1:0] pend_q,      pend_d;
    logic [VW-1:0]   vec_q [NREQ];
    logic [VW-1:0]   vec_d [NREQ];
    logic [IDW-1:0]  ptr_q,       ptr_d;
    logic [IDW-1:0]  gid_q,       gid_d;
    logic [VW-1:0]   enc_src_q,   enc_src_d;
    logic            enc_valid_q, enc_valid_d;
    logic            rdy_resp_q,  rdy_resp_d;
    logic [IDW-1:0]  resp_id_q,   resp_id_d;
    logic [IW-1:0]   resp_idx_q,  resp_idx_d;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;

    // Round-robin winner: first pending slot at or after ptr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (pend_q[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state: slot loading, issue sequencing and response capture.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        vec_d       = vec_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        enc_src_d   = enc_src_q;
        enc_valid_d = enc_valid_q;
        rdy_resp_d  = rdy_resp_q;
        resp_id_d   = resp_id_q;
        resp_idx_d  = resp_idx_q;

        // A full slot ignores further enqueues so the held vector is kept.
        for (int i = 0; i < NREQ; i++) begin
            if (bus.EN_req[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                vec_d[i]  = bus.req_vec[i*VW +: VW];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    enc_src_d   = vec_q[win_id];
                    enc_valid_d = 1'b1;
                    gid_d       = win_id;
                    state_d     = ST_SAMPLE;
                end else begin
                    enc_src_d   = '0;
                    enc_valid_d = 1'b0;
                end
            end
            ST_SAMPLE: begin
                // The slot stays busy through this cycle and frees at the edge.
                resp_idx_d    = bus.enc_result;
                resp_id_d     = gid_q;
                pend_d[gid_q] = 1'b0;
                ptr_d         = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
                enc_src_d     = '0;
                enc_valid_d   = 1'b0;
                rdy_resp_d    = 1'b1;
                state_d       = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.EN_resp) begin
                    rdy_resp_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset drops every slot and any held response.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                vec_q[i] <= '0;
            end
            ptr_q       <= '0;
            gid_q       <= '0;
            enc_src_q   <= '0;
            enc_valid_q <= 1'b0;
            rdy_resp_q  <= 1'b0;
            resp_id_q   <= '0;
            resp_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            vec_q       <= vec_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            enc_src_q   <= enc_src_d;
            enc_valid_q <= enc_valid_d;
            rdy_resp_q  <= rdy_resp_d;
            resp_id_q   <= resp_id_d;
            resp_idx_q  <= resp_idx_d;
        end
    end

    assign bus.RDY_req     = ~pend_q;
    assign bus.enc_src     = enc_src_q;
    assign bus.enc_valid   = enc_valid_q;
    assign bus.RDY_resp    = rdy_resp_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_idx    = resp_idx_q;
    assign bus.resp_zero   = (resp_idx_q == IW'(VW));
    assign bus.mv_busy     = (state_q != ST_IDLE) || (|pend_q);
    assign bus.RDY_mv_busy = 1'b1;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_enc_share_arbiter.sv
// Bench for enc_share_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_enc_share_arbiter;
    localparam int NREQ = 4;
    localparam int VW   = 32;
    localparam int IW   = 6;
    localparam int IDW  = 2;
    localparam int EW   = IDW + IW;

    logic       CLK;
    logic       RST_N;
    logic [1:0] dbg_state;

    enc_share_arbiter_if #(.NREQ(NREQ), .VW(VW), .IW(IW)) bus ();

    enc_share_arbiter #(.NREQ(NREQ), .VW(VW), .IW(IW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- leading-one encoder ----------------
    function automatic logic [IW-1:0] lead_one(input logic [VW-1:0] v);
        int pos;
        pos = VW;
        for (int i = 0; i < VW; i++) begin
            if (pos == VW && v[VW-1-i]) pos = i;
        end
        return IW'(pos);
    endfunction

    assign bus.enc_result = lead_one(bus.enc_src);

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Slots are a pending mask plus stored vectors; a grant is tracked by its
    // age in cycles: age 1 is the encoder cycle, age 2+ the response is held.
    logic [NREQ-1:0] m_pend;
    logic [VW-1:0]   m_vec [NREQ];
    int              m_ptr;
    int              m_g;
    int              m_a;
    logic [VW-1:0]   m_gvec;
    logic [EW-1:0]   exp_q[$];
    int              obs_q[$];

    task automatic model_reset();
        m_pend = '0;
        for (int i = 0; i < NREQ; i++) m_vec[i] = '0;
        m_ptr  = 0;
        m_g    = -1;
        m_a    = 0;
        m_gvec = '0;
        exp_q.delete();
    endtask

    task automatic model_check();
        logic            exp_valid;
        logic            exp_resp;
        logic [NREQ-1:0] free_mask;
        logic [EW-1:0]   e;
        exp_valid = (m_g >= 0) && (m_a == 1);
        exp_resp  = (m_g >= 0) && (m_a >= 2);
        free_mask = ~m_pend;
        chk("rdy_req", 64'(bus.RDY_req), 64'(free_mask));
        chk("enc_valid", 64'(bus.enc_valid), 64'(exp_valid));
        chk("enc_src", 64'(bus.enc_src), exp_valid ? 64'(m_gvec) : 64'(0));
        chk("rdy_resp", 64'(bus.RDY_resp), 64'(exp_resp));
        chk("mv_busy", 64'(bus.mv_busy), 64'((m_g >= 0) || (|m_pend)));
        chk("rdy_mv_busy", 64'(bus.RDY_mv_busy), 64'(1));
        if (exp_resp && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("resp_id", 64'(bus.resp_id), 64'(e[EW-1:IW]));
            chk("resp_idx", 64'(bus.resp_idx), 64'(e[IW-1:0]));
            chk("resp_zero", 64'(bus.resp_zero), 64'(e[IW-1:0] == IW'(VW)));
            if (bus.EN_resp) begin
                obs_q.push_back(int'(bus.resp_id));
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic model_update();
        logic [NREQ-1:0] old_pend;
        int              idx;
        if (!RST_N) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        if (m_g < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (m_g < 0 && old_pend[idx]) begin
                    m_g    = idx;
                    m_a    = 1;
                    m_gvec = m_vec[idx];
                    exp_q.push_back({IDW'(idx), lead_one(m_vec[idx])});
                end
            end
        end else if (m_a == 1) begin
            m_pend[m_g] = 1'b0;
            m_ptr       = (m_g + 1) % NREQ;
            m_a         = 2;
        end else if (bus.EN_resp) begin
            m_g = -1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.EN_req[i] && !old_pend[i]) begin
                m_pend[i] = 1'b1;
                m_vec[i]  = bus.req_vec[i*VW +: VW];
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLK);
        model_check();
        model_update();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus.EN_req  = '0;
        bus.req_vec = '0;
        bus.EN_resp = 1'b0;
    endtask

    task automatic drive_enq(input int slot, input logic [VW-1:0] v);
        bus.EN_req[slot]            = 1'b1;
        bus.req_vec[slot*VW +: VW] = v;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST_N = 1'b0;
        model_reset();
        tick();
        tick();
        RST_N = 1'b1;
        obs_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int            slot;
        logic [VW-1:0] vec;
        logic [IW-1:0] exp_idx;
        logic          exp_zero;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{2, 32'h0000_8000, 6'd16, 1'b0};
        tbl[1] = '{0, 32'h0000_0000, 6'd32, 1'b1};
        tbl[2] = '{1, 32'h8000_0000, 6'd0,  1'b0};
        tbl[3] = '{3, 32'h0000_0001, 6'd31, 1'b0};
        tbl[4] = '{2, 32'hFFFF_FFFF, 6'd0,  1'b0};
        tbl[5] = '{1, 32'h0001_0000, 6'd15, 1'b0};
        tbl[6] = '{3, 32'h4000_0000, 6'd1,  1'b0};

        clear_inputs();
        RST_N = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        // Reset state
        chk("reset_rdy_req", 64'(bus.RDY_req), 64'(4'hF));
        chk("reset_enc_valid", 64'(bus.enc_valid), 64'(0));
        chk("reset_enc_src", 64'(bus.enc_src), 64'(0));
        chk("reset_rdy_resp", 64'(bus.RDY_resp), 64'(0));
        chk("reset_resp_id", 64'(bus.resp_id), 64'(0));
        chk("reset_resp_idx", 64'(bus.resp_idx), 64'(0));
        chk("reset_mv_busy", 64'(bus.mv_busy), 64'(0));
        chk("reset_rdy_mv_busy", 64'(bus.RDY_mv_busy), 64'(1));
        do_reset();

        // Single requests: latency and encoding
        for (int t = 0; t < 7; t++) begin
            drive_enq(tbl[t].slot, tbl[t].vec);
            tick();                                   // cycle 0
            clear_inputs();
            chk("t_c1_enc_valid", 64'(bus.enc_valid), 64'(0));
            chk("t_c1_rdy_req", 64'(bus.RDY_req[tbl[t].slot]), 64'(0));
            tick();                                   // cycle 1
            chk("t_c2_enc_valid", 64'(bus.enc_valid), 64'(1));
            chk("t_c2_enc_src", 64'(bus.enc_src), 64'(tbl[t].vec));
            chk("t_c2_rdy_req", 64'(bus.RDY_req[tbl[t].slot]), 64'(0));
            tick();                                   // cycle 2
            chk("t_c3_rdy_resp", 64'(bus.RDY_resp), 64'(1));
            chk("t_c3_resp_id", 64'(bus.resp_id), 64'(tbl[t].slot));
            chk("t_c3_resp_idx", 64'(bus.resp_idx), 64'(tbl[t].exp_idx));
            chk("t_c3_resp_zero", 64'(bus.resp_zero), 64'(tbl[t].exp_zero));
            chk("t_c3_rdy_req", 64'(bus.RDY_req[tbl[t].slot]), 64'(1));
            chk("t_c3_enc_valid", 64'(bus.enc_valid), 64'(0));
            bus.EN_resp = 1'b1;
            tick();                                   // cycle 3
            clear_inputs();
            chk("t_c4_rdy_resp", 64'(bus.RDY_resp), 64'(0));
        end

        // Round robin with all four requesting, then re-enqueue 0 and 3
        do_reset();
        bus.EN_resp = 1'b1;
        for (int c = 0; c < 18; c++) begin
            bus.EN_req = '0;
            if (c == 0) begin
                for (int i = 0; i < NREQ; i++) drive_enq(i, $urandom());
            end else if (c == 6) begin
                drive_enq(0, 32'h0000_0400);
                drive_enq(3, 32'h0000_0002);
            end
            tick();
        end
        clear_inputs();
        chk("rr_count", 64'(obs_q.size()), 64'(5));
        if (obs_q.size() == 5) begin
            chk("rr_order0", 64'(obs_q[0]), 64'(0));
            chk("rr_order1", 64'(obs_q[1]), 64'(1));
            chk("rr_order2", 64'(obs_q[2]), 64'(2));
            chk("rr_order3", 64'(obs_q[3]), 64'(3));
            chk("rr_order4", 64'(obs_q[4]), 64'(0));
        end

        // Backpressure: response held 10 cycles, idle slot still accepted
        do_reset();
        drive_enq(0, 32'h0000_0100);
        drive_enq(1, 32'h00F0_0000);
        tick();
        clear_inputs();
        tick();
        tick();
        for (int j = 0; j < 10; j++) begin
            chk("bp_rdy_resp", 64'(bus.RDY_resp), 64'(1));
            chk("bp_resp_id", 64'(bus.resp_id), 64'(0));
            chk("bp_resp_idx", 64'(bus.resp_idx), 64'(23));
            chk("bp_enc_valid", 64'(bus.enc_valid), 64'(0));
            chk("bp_rdy_req1", 64'(bus.RDY_req[1]), 64'(0));
            chk("bp_mv_busy", 64'(bus.mv_busy), 64'(1));
            if (j >= 3) chk("bp_rdy_req2", 64'(bus.RDY_req[2]), 64'(0));
            if (j == 2) drive_enq(2, 32'h0000_0002);
            tick();
            clear_inputs();
        end
        bus.EN_resp = 1'b1;
        for (int j = 0; j < 12; j++) tick();
        clear_inputs();
        chk("bp_count", 64'(obs_q.size()), 64'(3));
        if (obs_q.size() == 3) begin
            chk("bp_order1", 64'(obs_q[1]), 64'(1));
            chk("bp_order2", 64'(obs_q[2]), 64'(2));
        end

        // Enqueue into a full slot is dropped
        do_reset();
        drive_enq(1, 32'h0000_0010);
        tick();
        clear_inputs();
        drive_enq(1, 32'hFFFF_FFFF);
        tick();
        clear_inputs();
        chk("pv_enc_src", 64'(bus.enc_src), 64'(32'h0000_0010));
        tick();
        chk("pv_resp_id", 64'(bus.resp_id), 64'(1));
        chk("pv_resp_idx", 64'(bus.resp_idx), 64'(27));
        bus.EN_resp = 1'b1;
        tick();
        clear_inputs();
        chk("pv_mv_busy", 64'(bus.mv_busy), 64'(0));
        tick();
        chk("pv_rdy_resp", 64'(bus.RDY_resp), 64'(0));

        // Asynchronous reset in the encoder cycle
        do_reset();
        drive_enq(0, 32'h0000_0800);
        tick();
        clear_inputs();
        tick();
        chk("ar_enc_valid_before", 64'(bus.enc_valid), 64'(1));
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("ar_enc_valid", 64'(bus.enc_valid), 64'(0));
        chk("ar_rdy_resp", 64'(bus.RDY_resp), 64'(0));
        chk("ar_mv_busy", 64'(bus.mv_busy), 64'(0));
        chk("ar_rdy_req", 64'(bus.RDY_req), 64'(4'hF));
        tick();
        RST_N = 1'b1;
        bus.EN_resp = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk("ar_no_resp", 64'(bus.RDY_resp), 64'(0));
            tick();
        end
        clear_inputs();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.EN_req = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0)
                    bus.req_vec[i*VW +: VW] = '0;
                else
                    bus.req_vec[i*VW +: VW] = $urandom() >> $urandom_range(0, 31);
            end
            bus.EN_resp = ($urandom_range(0, 2) != 0);
            tick();
        end
        clear_inputs();
        bus.EN_resp = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        clear_inputs();
        chk("drain_exp_q", 64'(exp_q.size()), 64'(0));
        chk("drain_mv_busy", 64'(bus.mv_busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
